// File: rtl/regfile_16x32_if.sv
// Register file access bundle: one write port, two read ports, and the
// externally supplied PC+8 that address 15 aliases to.
interface regfile_16x32_if;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [31:0] pc_plus8;
  logic [31:0] rd1;
  logic [31:0] rd2;

  modport master (output we, wa, wd, ra1, ra2, pc_plus8, input rd1, rd2);
  modport slave  (input we, wa, wd, ra1, ra2, pc_plus8, output rd1, rd2);
endinterface

// File: rtl/regfile_16x32.sv
// 16-entry x 32-bit register file: R0-R14 are flops, R15 reads back pc_plus8.
// Writes land on the rising clk edge; writes to R15 are silently dropped.
// Reads are combinational on two independent ports.
// Optional macro REGFILE_BYPASS_EN: a read of the register being written
// this cycle returns wd (write-through) instead of the old stored value.
module regfile_16x32 #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  regfile_16x32_if.slave  rf
);

  localparam int NREG = 15;

  logic [NREG-1:0] wen;
  logic [31:0]     regs_q [NREG];
  logic [31:0]     regs_d [NREG];
  logic [31:0]     rview  [16];

  // Write decoder: one enable per stored register; wa=15 matches nothing.
  always_comb begin
    wen = '0;
    for (int i = 0; i < NREG; i++)
      wen[i] = rf.we && (rf.wa == 4'(i));
  end

  // Next-state: enabled register takes wd, all others hold.
  always_comb begin
    for (int i = 0; i < NREG; i++)
      regs_d[i] = wen[i] ? rf.wd : regs_q[i];
  end

  // Storage; reset is asynchronous and wins over any same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  // 16-entry read view so both ports index with the full 4-bit address.
  always_comb begin
    for (int i = 0; i < NREG; i++)
      rview[i] = regs_q[i];
    rview[15] = rf.pc_plus8;
  end

  // Read ports.
  always_comb begin
    rf.rd1 = rview[rf.ra1];
    rf.rd2 = rview[rf.ra2];
`ifdef REGFILE_BYPASS_EN
    // Write-through, suppressed during reset so reads show the reset value.
    if (!reset && rf.we && rf.wa != 4'hF) begin
      if (rf.ra1 == rf.wa) rf.rd1 = rf.wd;
      if (rf.ra2 == rf.wa) rf.rd2 = rf.wd;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_16x32.sv
// Self-checking bench for regfile_16x32: directed cases plus random traffic
// against an array model of the architectural registers.
module tb_regfile_16x32;

  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_16x32_if rf_if ();

  regfile_16x32 #(.RESET_VAL(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  logic [31:0] model [15];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Architectural read value for address a given the current inputs.
  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return rf_if.pc_plus8;
    if (BYP && !reset && rf_if.we && rf_if.wa != 4'd15 && rf_if.wa == a) return rf_if.wd;
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) model[i] = RV;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] ra1, input logic [3:0] ra2);
    rf_if.we  = we;
    rf_if.wa  = wa;
    rf_if.wd  = wd;
    rf_if.ra1 = ra1;
    rf_if.ra2 = ra2;
    #1;
  endtask

  // Advance one clock edge; settle just after it.
  task automatic tick();
    if (!reset && rf_if.we && rf_if.wa != 4'd15) model[rf_if.wa] = rf_if.wd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ports(input string tag);
    chk({tag, "_rd1"}, rf_if.rd1, exp_rd(rf_if.ra1));
    chk({tag, "_rd2"}, rf_if.rd2, exp_rd(rf_if.ra2));
  endtask

  initial begin
    reset = 1'b1;
    rf_if.pc_plus8 = 32'h0000_0108;
    model_reset();
    // Reset state on every address, with a write attempted during reset.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'd4, 32'hCAFE_F00D, 4'(i), 4'(15 - i));
      chk("rst_rd1", rf_if.rd1, (i == 15) ? 32'h0000_0108 : RV);
      chk("rst_rd2", rf_if.rd2, (i == 0) ? 32'h0000_0108 : RV);
    end
    drive(1'b1, 4'd4, 32'hCAFE_F00D, 4'd4, 4'd4);
    tick();
    reset = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 4'd4, 4'd4);
    chk("rst_write_lost", rf_if.rd1, RV);
    tick();

    // Write R5 then read it on both ports; others untouched.
    drive(1'b1, 4'd5, 32'hDEAD_BEEF, 4'd0, 4'd1);
    tick();
    drive(1'b0, 4'd5, 32'h0, 4'd5, 4'd5);
    chk("wr5_rd1", rf_if.rd1, 32'hDEAD_BEEF);
    chk("wr5_rd2", rf_if.rd2, 32'hDEAD_BEEF);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 4'd0, 32'h0, 4'(i), 4'(i));
      chk("wr5_others", rf_if.rd1, (i == 5) ? 32'hDEAD_BEEF : RV);
    end

    // Write to R15 is ignored; R15 follows pc_plus8.
    drive(1'b1, 4'd15, 32'hFFFF_FFFF, 4'd0, 4'd15);
    chk("r15_pre", rf_if.rd2, 32'h0000_0108);
    tick();
    chk("r15_post", rf_if.rd2, 32'h0000_0108);
    rf_if.pc_plus8 = 32'h0000_0210;
    drive(1'b0, 4'd0, 32'h0, 4'd15, 4'd15);
    chk("r15_pc_follow", rf_if.rd1, 32'h0000_0210);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 4'd0, 32'h0, 4'(i), 4'(i));
      chk("r15_no_side", rf_if.rd2, (i == 5) ? 32'hDEAD_BEEF : RV);
    end

    // Same-cycle write/read of R7.
    drive(1'b1, 4'd7, 32'hA, 4'd7, 4'd0);
    tick();
    drive(1'b1, 4'd7, 32'hB, 4'd7, 4'd7);
    chk("hazard_pre", rf_if.rd1, BYP ? 32'hB : 32'hA);
    tick();
    drive(1'b0, 4'd7, 32'h0, 4'd7, 4'd7);
    chk("hazard_post", rf_if.rd1, 32'hB);

    // Hold with we=0.
    drive(1'b1, 4'd2, 32'h1, 4'd0, 4'd0);
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 4'd2, 32'h5555_5555, 4'd2, 4'd2);
      chk("hold", rf_if.rd1, 32'h1);
      tick();
    end

    // Sweep R0-R14.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 4'(i), 32'h100 + 32'(i), 4'd15, 4'd15);
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 4'd0, 32'h0, 4'(i), 4'(14 - i));
      chk("sweep_rd1", rf_if.rd1, 32'h100 + 32'(i));
      chk("sweep_rd2", rf_if.rd2, 32'h100 + 32'(14 - i));
    end

    // Asynchronous reset mid-cycle.
    drive(1'b1, 4'd3, 32'h1234_5678, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd3);
    chk("async_pre", rf_if.rd1, 32'h1234_5678);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst", rf_if.rd1, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rf_if.pc_plus8 = $urandom;
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        rf_if.ra1 = rf_if.wa;
        #1;
      end
      chk_ports("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_16x32.md
REGFILE_16X32 -- requirements
Module: regfile_16x32

Interface
REQ-001 Parameter RESET_VAL, default 32'h0000_0000, value loaded into R0-R14 on reset.
REQ-002 clk  input  1  rising-edge clock for all storage.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 we  input  1  write enable; 1 = write wd into register wa at the next rising clk edge.
REQ-005 wa  input  4  write address, R0-R15.
REQ-006 wd  input  32  write data.
REQ-007 ra1  input  4  read address, port 1.
REQ-008 ra2  input  4  read address, port 2.
REQ-009 pc_plus8  input  32  current PC+8, supplied by fetch logic.
REQ-010 rd1  output  32  read data, port 1.
REQ-011 rd2  output  32  read data, port 2.

Function
REQ-012 Storage SHALL be 15 enabled 32-bit registers (R0-R14), each holding its value unless its write enable is asserted.
REQ-013 A 4-to-16 write decoder SHALL assert the enable of exactly one register, wa, and only when we=1.
REQ-014 Writes SHALL take effect on the rising clk edge; the new value SHALL be visible on rd1/rd2 in the cycle after that edge.
REQ-015 we=1 with wa=15 SHALL be ignored; no stored register changes and no error is flagged.
REQ-016 Reads SHALL be combinational, with zero-cycle latency from ra1/ra2 to rd1/rd2.
REQ-017 ra=15 on either port SHALL return pc_plus8 combinationally, independent of we/wa/wd.
REQ-018 Both ports SHALL be able to read the same address in the same cycle and return identical data.
REQ-019 we=0 SHALL leave all registers unchanged regardless of wa and wd.
REQ-020 Write and read of the same address in one cycle SHALL be resolved per REQ-026 and REQ-027.
REQ-021 Outputs SHALL never be X once reset has been applied.

Reset
REQ-022 reset=1 SHALL load RESET_VAL into R0-R14 immediately, without waiting for clk.
REQ-023 During reset, rd1/rd2 SHALL show RESET_VAL for addresses 0-14 and pc_plus8 for address 15.
REQ-024 Reset SHALL override a write in the same cycle; the write is lost.
REQ-025 Normal operation SHALL resume at the first rising clk edge after reset deasserts.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined: when we=1, wa!=15 and ra1 (or ra2) equals wa, that port SHALL return wd in the same cycle (write-through).
REQ-027 With REGFILE_BYPASS_EN undefined: that port SHALL return the old stored value until the clock edge; the new value appears the following cycle.

Verification
REQ-028 Reset: assert reset mid-cycle with R3=32'h1234_5678 -> rd1 (ra1=3) reads 32'h0 before the next clk edge.
REQ-029 Write/read: we=1, wa=5, wd=32'hDEAD_BEEF, one edge; then ra1=5, ra2=5 -> both ports read 32'hDEAD_BEEF, and all other registers are unchanged.
REQ-030 R15: we=1, wa=15, wd=32'hFFFF_FFFF; pc_plus8=32'h0000_0108, ra2=15 -> rd2=32'h0000_0108 before and after the edge.
REQ-031 Same-cycle hazard: R7=32'hA, then we=1, wa=7, wd=32'hB, ra1=7 -> rd1=32'hB before the edge with REGFILE_BYPASS_EN, 32'hA without; 32'hB after the edge in both builds.
REQ-032 Hold: we=0, wa=2, wd=32'h5555_5555 for 10 cycles with R2=32'h1 -> rd1 (ra1=2) stays 32'h1.
REQ-033 Sweep: write R0-R14 with value 32'h100+i, then read all 15 registers on both ports -> each reads 32'h100+i.
